// File: rtl/cim_macro_model_v2.sv
// Behavioural compute-in-memory macro: binary-weight popcount MAC per bit-line column,
// with DAC / CIM / ADC phase latencies and a saturating ADC code buffer.
module cim_macro_model_v2 #(
  parameter int P_NUM_INPUTS   = 64,
  parameter int P_ADC_CHANNELS = 20,
  parameter int P_ADC_BITS     = 8,
  parameter int P_DAC_LAT      = 1,
  parameter int P_CIM_LAT      = 4,
  parameter int P_ADC_LAT      = 2,
  parameter int P_GAIN_SHIFT   = 2,
  localparam int SEL_W = $clog2(P_ADC_CHANNELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [P_NUM_INPUTS-1:0] wl_spike,
  input  logic                    dac_valid,
  output logic                    dac_ready,
  input  logic                    cim_start,
  output logic                    cim_done,
  input  logic                    adc_start,
  input  logic                    adc_mode,
  output logic                    adc_done,
  input  logic [SEL_W-1:0]        bl_sel,
  output logic [P_ADC_BITS-1:0]   bl_data,
  input  logic                    wgt_we,
  input  logic [SEL_W-1:0]        wgt_addr,
  input  logic [P_NUM_INPUTS-1:0] wgt_wdata,
  output logic                    busy,
  output logic                    err,
  input  logic                    err_clr
);
  localparam int AW    = $clog2(P_NUM_INPUTS + 1);
  localparam int QW    = AW + P_GAIN_SHIFT + P_ADC_BITS;
  localparam int LMAX  = (P_DAC_LAT > P_CIM_LAT) ? ((P_DAC_LAT > P_ADC_LAT) ? P_DAC_LAT : P_ADC_LAT)
                                                 : ((P_CIM_LAT > P_ADC_LAT) ? P_CIM_LAT : P_ADC_LAT);
  localparam int CNT_W = $clog2(LMAX + 1);
  localparam logic [QW-1:0] QMAX = {{(QW-P_ADC_BITS){1'b0}}, {P_ADC_BITS{1'b1}}};
  localparam logic [SEL_W:0] NCH = (SEL_W+1)'(P_ADC_CHANNELS);

  typedef enum logic [1:0] {IDLE, DAC, CIM, ADC} state_t;
  state_t state, state_nx;

  logic [P_ADC_CHANNELS-1:0][P_NUM_INPUTS-1:0] wgt;
  logic [P_ADC_CHANNELS-1:0][AW-1:0]           acc;
  logic [P_ADC_CHANNELS-1:0][P_ADC_BITS-1:0]   adc_buf;
  logic [P_NUM_INPUTS-1:0] wl_q;
  logic                    wl_valid, acc_valid, mode_q, err_q, cim_done_q, adc_done_q;
  logic [SEL_W-1:0]        sel_q, ch, idx;
  logic [CNT_W-1:0]        cnt;
  logic                    dac_acc, cim_acc, adc_acc, wgt_acc, err_set;
  logic                    lat_hit, cim_fin, adc_wr, adc_fin;
  logic [QW-1:0]           wide;
  logic [P_ADC_BITS-1:0]   code;

  function automatic logic [AW-1:0] popcnt(input logic [P_NUM_INPUTS-1:0] v);
    logic [AW-1:0] s;
    s = '0;
    for (int i = 0; i < P_NUM_INPUTS; i++) s = s + AW'(v[i]);
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dac_acc  = 1'b0;
    cim_acc  = 1'b0;
    adc_acc  = 1'b0;
    wgt_acc  = 1'b0;
    err_set  = 1'b0;
    lat_hit  = 1'b0;
    cim_fin  = 1'b0;
    adc_wr   = 1'b0;
    adc_fin  = 1'b0;
    case (state)
      DAC: lat_hit = (cnt == CNT_W'(P_DAC_LAT - 1));
      CIM: lat_hit = (cnt == CNT_W'(P_CIM_LAT - 1));
      ADC: lat_hit = (cnt == CNT_W'(P_ADC_LAT - 1));
      default: lat_hit = 1'b0;
    endcase
    case (state)
      IDLE: begin
        // Priority: WL load, then compute, then conversion; losers of a same-cycle clash flag err.
        if (dac_valid) begin
          dac_acc  = 1'b1;
          state_nx = DAC;
          err_set  = cim_start | adc_start;
        end else if (cim_start) begin
          if (wl_valid) begin
            cim_acc  = 1'b1;
            state_nx = CIM;
          end
          err_set = !wl_valid | adc_start;
        end else if (adc_start) begin
          if (acc_valid && (adc_mode || ({1'b0, bl_sel} < NCH))) begin
            adc_acc  = 1'b1;
            state_nx = ADC;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      DAC: if (lat_hit) state_nx = IDLE;
      CIM: if (lat_hit) begin
        cim_fin  = 1'b1;
        state_nx = IDLE;
      end
      ADC: if (lat_hit) begin
        adc_wr = 1'b1;
        if (!mode_q || ch == SEL_W'(P_ADC_CHANNELS - 1)) begin
          adc_fin  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (state != IDLE && (cim_start || adc_start)) err_set = 1'b1;
    if (wgt_we) begin
      if (state == IDLE && ({1'b0, wgt_addr} < NCH)) wgt_acc = 1'b1;
      else                                           err_set = 1'b1;
    end
  end

  always_comb begin
    idx  = mode_q ? ch : sel_q;
    wide = QW'(acc[idx]) << P_GAIN_SHIFT;
    code = (wide > QMAX) ? {P_ADC_BITS{1'b1}} : wide[P_ADC_BITS-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wgt        <= '0;
      acc        <= '0;
      adc_buf    <= '0;
      wl_q       <= '0;
      wl_valid   <= 1'b0;
      acc_valid  <= 1'b0;
      mode_q     <= 1'b0;
      sel_q      <= '0;
      ch         <= '0;
      cnt        <= '0;
      err_q      <= 1'b0;
      cim_done_q <= 1'b0;
      adc_done_q <= 1'b0;
    end else begin
      cim_done_q <= cim_fin;
      adc_done_q <= adc_fin;
      err_q      <= (err_q & ~err_clr) | err_set;
      if (state == IDLE || lat_hit) cnt <= '0;
      else                          cnt <= cnt + CNT_W'(1);
      if (dac_acc) begin
        wl_q      <= wl_spike;
        wl_valid  <= 1'b1;
        acc_valid <= 1'b0;
      end
      if (wgt_acc) begin
        wgt[wgt_addr] <= wgt_wdata;
        acc_valid     <= 1'b0;
      end
      if (cim_fin) begin
        for (int c = 0; c < P_ADC_CHANNELS; c++) acc[c] <= popcnt(wl_q & wgt[c]);
        acc_valid <= 1'b1;
      end
      if (adc_acc) begin
        mode_q <= adc_mode;
        sel_q  <= bl_sel;
        ch     <= '0;
      end
      if (adc_wr) begin
        adc_buf[idx] <= code;
        if (mode_q) ch <= ch + SEL_W'(1);
      end
    end
  end

  // Outputs are forced low while reset is asserted, independent of register contents.
  assign dac_ready = rst_n && (state == IDLE);
  assign busy      = rst_n && (state != IDLE);
  assign err       = rst_n && err_q;
  assign cim_done  = rst_n && cim_done_q;
  assign adc_done  = rst_n && adc_done_q;
  assign bl_data   = (rst_n && ({1'b0, bl_sel} < NCH)) ? adc_buf[bl_sel] : '0;

endmodule

// File: tb/tb_cim_macro_model_v2.sv
// Directed bench for cim_macro_model_v2 with default parameters (64 WL, 20 columns, 8-bit ADC).
module tb_cim_macro_model_v2;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] wl_spike;
  logic        dac_valid, dac_ready, cim_start, cim_done, adc_start, adc_mode, adc_done;
  logic [4:0]  bl_sel, wgt_addr;
  logic [7:0]  bl_data;
  logic        wgt_we, busy, err, err_clr;
  logic [63:0] wgt_wdata;

  int tests = 0;
  int fails = 0;
  logic [63:0] wm [20];
  logic [63:0] wl_m;
  logic        cim_d, adc_d;
  int          n;
  logic        seen;

  cim_macro_model_v2 dut (
    .clk(clk), .rst_n(rst_n), .wl_spike(wl_spike), .dac_valid(dac_valid), .dac_ready(dac_ready),
    .cim_start(cim_start), .cim_done(cim_done), .adc_start(adc_start), .adc_mode(adc_mode),
    .adc_done(adc_done), .bl_sel(bl_sel), .bl_data(bl_data), .wgt_we(wgt_we), .wgt_addr(wgt_addr),
    .wgt_wdata(wgt_wdata), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_code(input int c);
    int v;
    v = $countones(wl_m & wm[c]) << 2;
    return (v > 255) ? 255 : v;
  endfunction

  // n = edges after the accepting edge until the pulse is seen, -1 on timeout.
  task automatic wait_done(input bit use_adc, input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (use_adc ? adc_done : cim_done) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic wr_w(input int a, input logic [63:0] d);
    wgt_we = 1'b1; wgt_addr = 5'(a); wgt_wdata = d;
    tick();
    wgt_we = 1'b0;
    wm[a] = d;
  endtask

  task automatic send_wl(input logic [63:0] v);
    dac_valid = 1'b1; wl_spike = v;
    tick();
    dac_valid = 1'b0;
    wl_m = v;
    chk("dac_busy", busy, 1);
    tick();
    chk("dac_ready_back", dac_ready, 1);
  endtask

  task automatic run_cim();
    int k;
    cim_start = 1'b1;
    tick();
    cim_start = 1'b0;
    wait_done(1'b0, 10, k);
    chk("cim_lat", k, 4);
  endtask

  task automatic run_adc(input bit mode, input int sel, input int exp_lat);
    int k;
    adc_mode = mode; bl_sel = 5'(sel); adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    wait_done(1'b1, 60, k);
    chk(mode ? "scan_lat" : "single_lat", k, exp_lat);
    chk("adc_idle", busy, 0);
  endtask

  task automatic check_buf(input bit zero);
    for (int c = 0; c < 20; c++) begin
      bl_sel = 5'(c);
      #1;
      chk(zero ? "buf_zero" : "scan_buf", bl_data, zero ? 0 : exp_code(c));
    end
  endtask

  always @(negedge clk) begin
    if (cim_done || adc_done) begin
      chk("done_excl", cim_done & adc_done, 0);
      chk("pulse_w", (cim_done & cim_d) | (adc_done & adc_d), 0);
    end
    cim_d <= cim_done;
    adc_d <= adc_done;
  end

  initial begin
    rst_n = 1'b0; wl_spike = '0; dac_valid = 0; cim_start = 0; adc_start = 0; adc_mode = 0;
    bl_sel = '0; wgt_we = 0; wgt_addr = '0; wgt_wdata = '0; err_clr = 0;
    for (int c = 0; c < 20; c++) wm[c] = '0;
    wl_m = '0;

    repeat (3) begin
      tick();
      chk("rst_outs", {dac_ready, busy, err, cim_done, adc_done, bl_data}, 0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_ready", dac_ready, 1);
    chk("rel_busy", busy, 0);
    chk("rel_err", err, 0);

    // cim_start with no WL loaded
    cim_start = 1'b1;
    tick();
    cim_start = 1'b0;
    chk("err_nowl", err, 1);
    wait_done(1'b0, 6, n);
    chk("no_cim_done", n, -1);
    err_clr = 1'b1; cim_start = 1'b1;
    tick();
    err_clr = 1'b0; cim_start = 1'b0;
    chk("err_clr_race", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err, 0);

    wr_w(0, '1);
    wr_w(10, 64'h0F);
    wr_w(5, 64'h181);
    send_wl(64'hFF);
    run_cim();
    run_adc(1'b0, 0, 2);
    chk("bl0", bl_data, 32);
    bl_sel = 5'd10;
    #1;
    chk("bl10_unconv", bl_data, 0);
    run_adc(1'b0, 10, 2);
    chk("bl10", bl_data, 16);

    // single mode with channel out of range
    adc_mode = 1'b0; bl_sel = 5'd25; adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    chk("err_sel", err, 1);
    chk("oor_data", bl_data, 0);
    wait_done(1'b1, 6, n);
    chk("no_adc_done", n, -1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    run_adc(1'b1, 0, 40);
    check_buf(1'b0);

    // weight write while computing is dropped
    cim_start = 1'b1;
    tick();
    cim_start = 1'b0;
    wgt_we = 1'b1; wgt_addr = 5'd1; wgt_wdata = '1;
    tick();
    wgt_we = 1'b0;
    chk("err_wgt_busy", err, 1);
    wait_done(1'b0, 10, n);
    chk("cim_lat_rest", n, 3);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    send_wl('1);
    run_cim();
    run_adc(1'b0, 0, 2);
    chk("sat", bl_data, 255);
    run_adc(1'b1, 0, 40);
    check_buf(1'b0);

    // reset 15 cycles into a scan
    seen = 1'b0;
    adc_mode = 1'b1; adc_start = 1'b1;
    tick();
    adc_start = 1'b0;
    repeat (14) begin
      tick();
      seen = seen | adc_done;
    end
    rst_n = 1'b0;
    tick();
    seen = seen | adc_done;
    rst_n = 1'b1;
    repeat (40) begin
      tick();
      seen = seen | adc_done;
    end
    chk("rst_no_done", seen, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", dac_ready, 1);
    check_buf(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cim_macro_model_v2.md
CIM_MACRO_MODEL_V2 -- requirements
Module: cim_macro_model_v2

Interface
REQ-001 SHALL have parameter P_NUM_INPUTS, default 64, WL vector width.
REQ-002 SHALL have parameter P_ADC_CHANNELS, default 20, BL column count (0..9 positive, 10..19 negative).
REQ-003 SHALL have parameter P_ADC_BITS, default 8, ADC code width.
REQ-004 SHALL have parameters P_DAC_LAT, P_CIM_LAT and P_ADC_LAT, defaults 1/4/2, per-phase latency in cycles; each SHALL be >=1.
REQ-005 SHALL have parameter P_GAIN_SHIFT, default 2, left shift applied to the column sum before quantisation.
REQ-006 Ports (SEL_W = $clog2(P_ADC_CHANNELS)); one clock, reset synchronous and active-low:
  clk  in  1  clock
  rst_n  in  1  synchronous active-low reset
  wl_spike  in  P_NUM_INPUTS  WL bit-plane
  dac_valid  in  1  WL data valid
  dac_ready  out  1  model accepts WL
  cim_start  in  1  compute request pulse
  cim_done  out  1  one-cycle compute-complete pulse
  adc_start  in  1  conversion request pulse
  adc_mode  in  1  0 = single channel (bl_sel), 1 = scan all channels
  adc_done  out  1  one-cycle conversion-complete pulse
  bl_sel  in  SEL_W  channel select for conversion and readout
  bl_data  out  P_ADC_BITS  code of channel bl_sel
  wgt_we  in  1  weight write strobe
  wgt_addr  in  SEL_W  weight column index
  wgt_wdata  in  P_NUM_INPUTS  binary weight row for the column
  busy  out  1  state != IDLE
  err  out  1  sticky protocol error
  err_clr  in  1  clears err

Function
REQ-007 SHALL implement the states IDLE, DAC, CIM, ADC; busy = (state != IDLE).
REQ-008 dac_ready SHALL be 1 only in IDLE with rst_n high.
REQ-009 In IDLE, dac_valid high SHALL latch wl_spike into wl_q, set wl_valid, clear acc_valid, and enter DAC for P_DAC_LAT cycles, then return to IDLE.
REQ-010 In IDLE with no dac_valid, cim_start with wl_valid=1 SHALL enter CIM.
REQ-011 On the P_CIM_LAT-th edge after acceptance, the block SHALL register acc[c] = popcount(wl_q & W[c]) for every c, using width $clog2(P_NUM_INPUTS+1).
REQ-012 On that same edge the block SHALL pulse cim_done for 1 cycle, set acc_valid and return to IDLE.
REQ-013 In IDLE with no dac_valid or cim_start, adc_start with acc_valid=1 SHALL enter ADC and latch adc_mode and bl_sel.
REQ-014 Quantisation SHALL compute code[c] = min(acc[c] << P_GAIN_SHIFT, 2^P_ADC_BITS-1), saturating with no wrap.
REQ-015 In single mode, the block SHALL write buf[sel_q] P_ADC_LAT edges after acceptance, pulse adc_done on that edge and return to IDLE.
REQ-016 In scan mode, the block SHALL write buf[0..P_ADC_CHANNELS-1] in order, one channel every P_ADC_LAT edges.
REQ-017 In scan mode, adc_done SHALL pulse with the last write (P_ADC_CHANNELS*P_ADC_LAT edges after acceptance), then return to IDLE.
REQ-018 bl_data SHALL equal buf[bl_sel] combinationally, and 0 when bl_sel >= P_ADC_CHANNELS.
REQ-019 A wgt_we in IDLE SHALL write W[wgt_addr] = wgt_wdata and clear acc_valid.
REQ-020 A wgt_we when busy, or with wgt_addr >= P_ADC_CHANNELS, SHALL be ignored and SHALL set err.
REQ-021 The following starts SHALL be ignored and SHALL set err:
  cim_start without wl_valid; adc_start without acc_valid; any start while busy; cim_start/adc_start in the same cycle as an accepted dac_valid; adc_start in the same cycle as an accepted cim_start; adc_start with bl_sel out of range in single mode.
REQ-022 err SHALL hold until err_clr; if err_clr and a new error occur in the same cycle, err SHALL remain 1.
REQ-023 cim_done and adc_done SHALL never be high in the same cycle and SHALL never last more than 1 cycle.

Reset
REQ-024 With rst_n low at a clk edge, the block SHALL go to IDLE and clear wl_q, W, acc, buf, wl_valid, acc_valid, counters and err.
REQ-025 With rst_n low, all outputs SHALL be 0, including dac_ready.
REQ-026 Reset mid-operation SHALL abort without a done pulse.
REQ-027 dac_ready SHALL be 1 in the first cycle with rst_n high.

Verification
REQ-028 Reset bench: hold rst_n low 3 cycles, then release -> all outputs 0 during reset; dac_ready=1, busy=0, err=0 after release.
REQ-029 Single conversion: W[0]=all-ones, W[10]=0x0F; WL=0xFF; cim_start; adc_start single with bl_sel=0, then bl_sel=10 -> cim_done 4 cycles after accept; adc_done 2 cycles after accept; bl_data=32, then 16.
REQ-030 Saturation: W[0] and WL all-ones (sum 64, shifted 256) -> bl_data=255.
REQ-031 Scan mode: adc_start with adc_mode=1 -> adc_done exactly 40 cycles after accept; all 20 buf entries match the model.
REQ-032 Errors: cim_start right after reset -> err=1, no cim_done; same cycle err_clr+cim_start -> err stays 1; err_clr alone -> err=0; wgt_we during CIM -> ignored, err=1.
REQ-033 Reset mid-scan (cycle 15 of 40) -> no adc_done; buf all 0; busy=0.
